// File: rtl/tb_l2_req_arbiter_if.sv
// Bundle of requester, L2 request/response and routed-response signals for the L2 request arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface tb_l2_req_arbiter_if #(
  parameter int REQ_N  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int CMD_W  = 2,
  parameter int SRC_W  = (REQ_N > 1) ? $clog2(REQ_N) : 1
);
  localparam int BE_W = DATA_W / 8;

  logic                              boot_mode;
  logic [REQ_N-1:0]                  req_valid;
  logic [REQ_N-1:0][CMD_W-1:0]       req_cmd;
  logic [REQ_N-1:0][ADDR_W-1:0]      req_addr;
  logic [REQ_N-1:0][TAG_W-1:0]       req_tag;
  logic [REQ_N-1:0][DATA_W-1:0]      req_data;
  logic [REQ_N-1:0][BE_W-1:0]        req_byte_en;
  logic [REQ_N-1:0]                  req_ready;

  logic                              l2_req_valid;
  logic [CMD_W-1:0]                  l2_req_cmd;
  logic [ADDR_W-1:0]                 l2_req_addr;
  logic [SRC_W+TAG_W-1:0]            l2_req_tag;
  logic [DATA_W-1:0]                 l2_req_data;
  logic [BE_W-1:0]                   l2_req_byte_en;
  logic                              l2_req_ready;

  logic                              l2_resp_valid;
  logic [SRC_W+TAG_W-1:0]            l2_resp_tag;
  logic [DATA_W-1:0]                 l2_resp_data;

  logic [REQ_N-1:0]                  resp_valid;
  logic [TAG_W-1:0]                  resp_tag;
  logic [DATA_W-1:0]                 resp_data;

  logic                              busy;
  logic                              route_err;

  modport slave (
    input  boot_mode, req_valid, req_cmd, req_addr, req_tag, req_data, req_byte_en,
    output req_ready,
    output l2_req_valid, l2_req_cmd, l2_req_addr, l2_req_tag, l2_req_data, l2_req_byte_en,
    input  l2_req_ready,
    input  l2_resp_valid, l2_resp_tag, l2_resp_data,
    output resp_valid, resp_tag, resp_data,
    output busy, route_err
  );

  modport master (
    output boot_mode, req_valid, req_cmd, req_addr, req_tag, req_data, req_byte_en,
    input  req_ready,
    input  l2_req_valid, l2_req_cmd, l2_req_addr, l2_req_tag, l2_req_data, l2_req_byte_en,
    output l2_req_ready,
    output l2_resp_valid, l2_resp_tag, l2_resp_data,
    input  resp_valid, resp_tag, resp_data,
    input  busy, route_err
  );
endinterface

// File: rtl/tb_l2_req_arbiter.sv
// Round-robin arbiter sharing the L2 request port between the ELF loader (index 0) and core requesters,
// with a one-entry output stage, source-prefixed tags and registered response routing.
module tb_l2_req_arbiter #(
  parameter int REQ_N  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4,
  parameter int CMD_W  = 2,
  parameter int SRC_W  = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  tb_l2_req_arbiter_if.slave   bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                  state_reg, state_next;
  logic [SRC_W-1:0]        rr_reg, rr_next;
  logic [REQ_N-1:0]        elig;
  logic                    grant_any;
  logic [SRC_W-1:0]        grant_idx;
  logic                    can_load;
  logic                    accept;

  logic [CMD_W-1:0]        cmd_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [SRC_W+TAG_W-1:0]  tag_reg;
  logic [DATA_W-1:0]       data_reg;
  logic [BE_W-1:0]         be_reg;

  logic [SRC_W-1:0]        resp_src;
  logic                    resp_in_range;
  logic [REQ_N-1:0]        resp_valid_reg;
  logic [TAG_W-1:0]        resp_tag_reg;
  logic [DATA_W-1:0]       resp_data_reg;
  logic                    route_err_reg;

  // Only the loader may compete while the program image is still being loaded.
  generate
    for (genvar gi = 0; gi < REQ_N; gi++) begin : g_elig
      if (gi == 0) begin : g_loader
        assign elig[gi] = bus.req_valid[gi];
      end else begin : g_core
        assign elig[gi] = bus.req_valid[gi] && !bus.boot_mode;
      end
    end
  endgenerate

  // Scan from the farthest slot back toward rr so the nearest eligible requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = REQ_N - 1; k >= 0; k--) begin
      idx = int'(rr_reg) + k;
      if (idx >= REQ_N) idx = idx - REQ_N;
      if (elig[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx[SRC_W-1:0];
      end
    end
  end

  assign can_load      = (state_reg == ST_EMPTY) || bus.l2_req_ready;
  assign accept        = can_load && grant_any && i_reset_n;
  assign bus.req_ready = accept ? (REQ_N'(1) << grant_idx) : '0;

  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    if (accept) begin
      state_next = ST_HOLD;
      rr_next    = (grant_idx == SRC_W'(REQ_N - 1)) ? '0 : grant_idx + SRC_W'(1);
    end else if (state_reg == ST_HOLD && bus.l2_req_ready) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= ST_EMPTY;
      rr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cmd_reg  <= '0;
      addr_reg <= '0;
      tag_reg  <= '0;
      data_reg <= '0;
      be_reg   <= '0;
    end else if (accept) begin
      cmd_reg  <= bus.req_cmd[grant_idx];
      addr_reg <= bus.req_addr[grant_idx];
      tag_reg  <= {grant_idx, bus.req_tag[grant_idx]};
      data_reg <= bus.req_data[grant_idx];
      be_reg   <= bus.req_byte_en[grant_idx];
    end
  end

  assign bus.l2_req_valid   = (state_reg == ST_HOLD);
  assign bus.busy           = (state_reg == ST_HOLD);
  assign bus.l2_req_cmd     = cmd_reg;
  assign bus.l2_req_addr    = addr_reg;
  assign bus.l2_req_tag     = tag_reg;
  assign bus.l2_req_data    = data_reg;
  assign bus.l2_req_byte_en = be_reg;

  // Responses whose source prefix names no requester are dropped and flagged.
  assign resp_src      = bus.l2_resp_tag[TAG_W +: SRC_W];
  assign resp_in_range = ({1'b0, resp_src} < (SRC_W + 1)'(REQ_N));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      resp_valid_reg <= '0;
      resp_tag_reg   <= '0;
      resp_data_reg  <= '0;
      route_err_reg  <= 1'b0;
    end else begin
      resp_valid_reg <= '0;
      if (bus.l2_resp_valid) begin
        if (resp_in_range) begin
          resp_valid_reg <= REQ_N'(1) << resp_src;
          resp_tag_reg   <= bus.l2_resp_tag[TAG_W-1:0];
          resp_data_reg  <= bus.l2_resp_data;
        end else begin
          route_err_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_tag   = resp_tag_reg;
  assign bus.resp_data  = resp_data_reg;
  assign bus.route_err  = route_err_reg;
endmodule

// File: tb/tb_tb_l2_req_arbiter.sv
// Directed bench for the L2 request arbiter: reset, single grant, round-robin, backpressure,
// boot mode, response routing and reset during a held request.
module tb_tb_l2_req_arbiter;
  localparam int REQ_N  = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 4;
  localparam int CMD_W  = 2;
  localparam int SRC_W  = 2;

  logic i_clk = 1'b0;
  logic i_reset_n;
  int   pass_cnt = 0;
  int   check_cnt = 0;

  tb_l2_req_arbiter_if #(
    .REQ_N(REQ_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .CMD_W(CMD_W), .SRC_W(SRC_W)
  ) bus ();

  tb_l2_req_arbiter #(
    .REQ_N(REQ_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TAG_W(TAG_W), .CMD_W(CMD_W), .SRC_W(SRC_W)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .bus(bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(int g);
    return 32'h1000_0000 + 32'(g * 256);
  endfunction

  function automatic logic [SRC_W+TAG_W-1:0] exp_tag(int g);
    return {2'(g), 4'(8 + g)};
  endfunction

  task automatic set_req_fields();
    for (int i = 0; i < REQ_N; i++) begin
      bus.req_addr[i]    = exp_addr(i);
      bus.req_tag[i]     = 4'(8 + i);
      bus.req_cmd[i]     = 2'(i + 1);
      bus.req_data[i]    = {32'hCAFE_0000 + 32'(i), 32'h1234_5678};
      bus.req_byte_en[i] = 8'hF0 | 8'(i);
    end
  endtask

  task automatic do_reset();
    i_reset_n         = 1'b0;
    bus.req_valid     = '0;
    bus.boot_mode     = 1'b0;
    bus.l2_req_ready  = 1'b0;
    bus.l2_resp_valid = 1'b0;
    step();
    step();
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 3'b111;
    #1;
    check_cnt++; if (bus.req_ready !== 3'b000) $display("FAIL reset_ready got=%b exp=000", bus.req_ready); else pass_cnt++;
    check_cnt++; if (bus.l2_req_valid !== 1'b0) $display("FAIL reset_l2_valid got=%b exp=0", bus.l2_req_valid); else pass_cnt++;
    check_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
    check_cnt++; if (bus.resp_valid !== 3'b000) $display("FAIL reset_resp_valid got=%b exp=000", bus.resp_valid); else pass_cnt++;
    check_cnt++; if (bus.route_err !== 1'b0) $display("FAIL reset_route_err got=%b exp=0", bus.route_err); else pass_cnt++;
    check_cnt++; if (bus.l2_req_addr !== 32'h0 || bus.l2_req_tag !== 6'h0) $display("FAIL reset_l2_fields got addr=%h tag=%h exp=0", bus.l2_req_addr, bus.l2_req_tag); else pass_cnt++;
    check_cnt++; if (bus.resp_data !== 64'h0 || bus.resp_tag !== 4'h0) $display("FAIL reset_resp_fields got data=%h tag=%h exp=0", bus.resp_data, bus.resp_tag); else pass_cnt++;
    bus.req_valid = '0;
    step();
    i_reset_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_single_requester();
    set_req_fields();
    bus.req_addr[1]  = 32'h8000_0040;
    bus.req_tag[1]   = 4'd5;
    bus.req_valid    = 3'b010;
    bus.l2_req_ready = 1'b1;
    #1;
    check_cnt++; if (bus.req_ready !== 3'b010) $display("FAIL single_ready got=%b exp=010", bus.req_ready); else pass_cnt++;
    step();
    bus.req_valid = '0;
    check_cnt++; if (bus.l2_req_valid !== 1'b1 || bus.busy !== 1'b1) $display("FAIL single_l2_valid got=%b busy=%b exp=1", bus.l2_req_valid, bus.busy); else pass_cnt++;
    check_cnt++; if (bus.l2_req_addr !== 32'h8000_0040) $display("FAIL single_addr got=%h exp=80000040", bus.l2_req_addr); else pass_cnt++;
    check_cnt++; if (bus.l2_req_tag !== 6'h15) $display("FAIL single_tag got=%h exp=15", bus.l2_req_tag); else pass_cnt++;
    check_cnt++; if (bus.l2_req_cmd !== 2'd2 || bus.l2_req_data !== 64'hCAFE_0001_1234_5678 || bus.l2_req_byte_en !== 8'hF1)
      $display("FAIL single_fields got cmd=%h data=%h be=%h exp cmd=2 data=cafe000112345678 be=f1", bus.l2_req_cmd, bus.l2_req_data, bus.l2_req_byte_en);
    else pass_cnt++;
    step();
    check_cnt++; if (bus.l2_req_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL single_drain got=%b busy=%b exp=0", bus.l2_req_valid, bus.busy); else pass_cnt++;
    set_req_fields();
    $display("test_single_requester: req1 addr=80000040 tag=5");
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    set_req_fields();
    bus.l2_req_ready = 1'b1;
    bus.req_valid    = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp = c % 3;
      #1;
      check_cnt++; if (bus.req_ready !== 3'(1 << exp)) $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, 3'(1 << exp)); else pass_cnt++;
      step();
      check_cnt++;
      if (bus.l2_req_valid !== 1'b1 || bus.l2_req_tag !== exp_tag(exp) || bus.l2_req_addr !== exp_addr(exp))
        $display("FAIL rr_out c=%0d got v=%b tag=%h addr=%h exp v=1 tag=%h addr=%h", c, bus.l2_req_valid, bus.l2_req_tag, bus.l2_req_addr, exp_tag(exp), exp_addr(exp));
      else pass_cnt++;
      $display("test_round_robin: cycle %0d expected grant %0d", c, exp);
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req_fields();
    bus.req_valid    = 3'b011;
    bus.l2_req_ready = 1'b0;
    #1;
    check_cnt++; if (bus.req_ready !== 3'b001) $display("FAIL bp_first_grant got=%b exp=001", bus.req_ready); else pass_cnt++;
    step();
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (bus.req_ready !== 3'b000 || bus.l2_req_valid !== 1'b1 || bus.l2_req_addr !== exp_addr(0) ||
          bus.l2_req_tag !== exp_tag(0) || bus.l2_req_data !== 64'hCAFE_0000_1234_5678)
        $display("FAIL bp_hold i=%0d got ready=%b v=%b addr=%h tag=%h exp ready=000 v=1 addr=%h tag=%h",
                 i, bus.req_ready, bus.l2_req_valid, bus.l2_req_addr, bus.l2_req_tag, exp_addr(0), exp_tag(0));
      else pass_cnt++;
      step();
    end
    bus.l2_req_ready = 1'b1;
    #1;
    check_cnt++; if (bus.req_ready !== 3'b010) $display("FAIL bp_release_grant got=%b exp=010", bus.req_ready); else pass_cnt++;
    step();
    bus.req_valid = '0;
    check_cnt++; if (bus.l2_req_valid !== 1'b1 || bus.l2_req_tag !== exp_tag(1)) $display("FAIL bp_next got v=%b tag=%h exp v=1 tag=%h", bus.l2_req_valid, bus.l2_req_tag, exp_tag(1)); else pass_cnt++;
    step();
    check_cnt++; if (bus.busy !== 1'b0) $display("FAIL bp_drain got=%b exp=0", bus.busy); else pass_cnt++;
    $display("test_backpressure: held req0 for 4 cycles, then req1");
  endtask

  task automatic test_boot_mode();
    bit got;
    do_reset();
    set_req_fields();
    bus.boot_mode    = 1'b1;
    bus.req_valid    = 3'b101;
    bus.l2_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_cnt++; if (bus.req_ready !== 3'b001) $display("FAIL boot_grant i=%0d got=%b exp=001", i, bus.req_ready); else pass_cnt++;
      step();
      check_cnt++; if (bus.l2_req_tag !== exp_tag(0)) $display("FAIL boot_tag i=%0d got=%h exp=%h", i, bus.l2_req_tag, exp_tag(0)); else pass_cnt++;
    end
    bus.boot_mode = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (bus.req_ready === 3'b100) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check_cnt++; if (got !== 1'b1) $display("FAIL boot_release_grant got=%b exp=1 (req2 within 2 cycles)", got); else pass_cnt++;
    step();
    check_cnt++; if (bus.l2_req_tag !== exp_tag(2)) $display("FAIL boot_release_tag got=%h exp=%h", bus.l2_req_tag, exp_tag(2)); else pass_cnt++;
    bus.req_valid = '0;
    step();
    $display("test_boot_mode: loader only for 10 cycles, then req2");
  endtask

  task automatic test_resp_routing();
    bus.l2_resp_valid = 1'b1;
    bus.l2_resp_tag   = 6'h23;
    bus.l2_resp_data  = 64'hDEAD_BEEF;
    step();
    bus.l2_resp_valid = 1'b0;
    check_cnt++; if (bus.resp_valid !== 3'b100) $display("FAIL resp2_valid got=%b exp=100", bus.resp_valid); else pass_cnt++;
    check_cnt++; if (bus.resp_tag !== 4'h3 || bus.resp_data !== 64'hDEAD_BEEF) $display("FAIL resp2_fields got tag=%h data=%h exp tag=3 data=deadbeef", bus.resp_tag, bus.resp_data); else pass_cnt++;
    check_cnt++; if (bus.route_err !== 1'b0) $display("FAIL resp2_err got=%b exp=0", bus.route_err); else pass_cnt++;
    step();
    check_cnt++; if (bus.resp_valid !== 3'b000) $display("FAIL resp_pulse got=%b exp=000", bus.resp_valid); else pass_cnt++;
    bus.l2_resp_valid = 1'b1;
    bus.l2_resp_tag   = 6'h07;
    bus.l2_resp_data  = 64'h0123_4567_89AB_CDEF;
    step();
    bus.l2_resp_valid = 1'b0;
    check_cnt++; if (bus.resp_valid !== 3'b001 || bus.resp_tag !== 4'h7 || bus.resp_data !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL resp0 got v=%b tag=%h data=%h exp v=001 tag=7 data=0123456789abcdef", bus.resp_valid, bus.resp_tag, bus.resp_data);
    else pass_cnt++;
    bus.l2_resp_valid = 1'b1;
    bus.l2_resp_tag   = 6'h31;
    bus.l2_resp_data  = 64'h5555;
    step();
    bus.l2_resp_valid = 1'b0;
    check_cnt++; if (bus.resp_valid !== 3'b000 || bus.route_err !== 1'b1) $display("FAIL resp_bad got v=%b err=%b exp v=000 err=1", bus.resp_valid, bus.route_err); else pass_cnt++;
    step();
    step();
    check_cnt++; if (bus.route_err !== 1'b1) $display("FAIL resp_err_sticky got=%b exp=1", bus.route_err); else pass_cnt++;
    $display("test_resp_routing: src2, src0, src3(dropped)");
  endtask

  task automatic test_reset_mid_hold();
    set_req_fields();
    bus.req_valid    = 3'b010;
    bus.l2_req_ready = 1'b0;
    #1;
    check_cnt++; if (bus.req_ready !== 3'b010) $display("FAIL mid_grant got=%b exp=010", bus.req_ready); else pass_cnt++;
    step();
    bus.req_valid = '0;
    check_cnt++; if (bus.l2_req_valid !== 1'b1) $display("FAIL mid_hold got=%b exp=1", bus.l2_req_valid); else pass_cnt++;
    #2;
    i_reset_n = 1'b0;
    #1;
    check_cnt++; if (bus.l2_req_valid !== 1'b0 || bus.busy !== 1'b0 || bus.route_err !== 1'b0)
      $display("FAIL mid_async got v=%b busy=%b err=%b exp 0", bus.l2_req_valid, bus.busy, bus.route_err);
    else pass_cnt++;
    bus.req_valid = 3'b111;
    #1;
    check_cnt++; if (bus.req_ready !== 3'b000) $display("FAIL mid_ready_in_reset got=%b exp=000", bus.req_ready); else pass_cnt++;
    #1;
    i_reset_n        = 1'b1;
    bus.l2_req_ready = 1'b1;
    #1;
    check_cnt++; if (bus.req_ready !== 3'b001) $display("FAIL mid_first_grant got=%b exp=001", bus.req_ready); else pass_cnt++;
    step();
    bus.req_valid = '0;
    check_cnt++; if (bus.l2_req_tag !== exp_tag(0)) $display("FAIL mid_first_tag got=%h exp=%h", bus.l2_req_tag, exp_tag(0)); else pass_cnt++;
    step();
    $display("test_reset_mid_hold: held req1 discarded, req0 first after release");
  endtask

  initial begin
    i_reset_n         = 1'b0;
    bus.boot_mode     = 1'b0;
    bus.req_valid     = '0;
    bus.req_cmd       = '0;
    bus.req_addr      = '0;
    bus.req_tag       = '0;
    bus.req_data      = '0;
    bus.req_byte_en   = '0;
    bus.l2_req_ready  = 1'b0;
    bus.l2_resp_valid = 1'b0;
    bus.l2_resp_tag   = '0;
    bus.l2_resp_data  = '0;
    step();
    test_reset();
    test_single_requester();
    test_round_robin();
    test_backpressure();
    test_boot_mode();
    test_resp_routing();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/tb_l2_req_arbiter.md
# tb_l2_req_arbiter

Registered round-robin arbiter that shares the single L2 request port between the ELF loader and the core-side requesters (ICache refill, DCache/LSU). It adds a one-entry output stage that honours `i_l2_req_ready`. It prefixes each outgoing tag with the source index and routes L2 responses back to the originating requester. A boot mode gates all non-loader traffic until program image loading completes.

## Interface
Parameters:
- `REQ_N`, 3, number of requesters; index 0 is always the ELF loader.
- `ADDR_W`, `riscv_pkg::PADDR_W`, request address width.
- `DATA_W`, `msrh_conf_pkg::ICACHE_DATA_W`, data width; byte-enable width is `DATA_W/8`.
- `TAG_W`, `msrh_lsu_pkg::L2_CMD_TAG_W`, requester tag width.
- `SRC_W`, `$clog2(REQ_N)` (minimum 1), width of the source-index prefix.

Ports:
- `i_clk` in 1: clock.
- `i_reset_n` in 1: reset, asynchronous, active-low. Clock is `i_clk`.
- `i_boot_mode` in 1: while 1, only requester 0 is eligible.
- `i_req_valid` in `[REQ_N]`: per-requester request valid.
- `i_req_cmd` in `[REQ_N]` of `msrh_lsu_pkg::mem_cmd_t`: command.
- `i_req_addr` in `[REQ_N]×ADDR_W`: address.
- `i_req_tag` in `[REQ_N]×TAG_W`: tag.
- `i_req_data` in `[REQ_N]×DATA_W`: write data.
- `i_req_byte_en` in `[REQ_N]×DATA_W/8`: byte enables.
- `o_req_ready` out `[REQ_N]`: grant; a request is accepted when valid and ready are both 1.
- `o_l2_req_valid`, `o_l2_req_cmd`, `o_l2_req_addr`, `o_l2_req_data`, `o_l2_req_byte_en` out: registered L2 request.
- `o_l2_req_tag` out `SRC_W+TAG_W`: `{src, tag}`.
- `i_l2_req_ready` in 1: L2 accepts the request.
- `i_l2_resp_valid` in 1, `i_l2_resp_tag` in `SRC_W+TAG_W`, `i_l2_resp_data` in `DATA_W`: L2 response.
- `o_resp_valid` out `[REQ_N]`, `o_resp_tag` out `TAG_W`, `o_resp_data` out `DATA_W`: routed response.
- `o_busy` out 1: output stage holds a request.
- `o_route_err` out 1: sticky flag, set when a response carries `src >= REQ_N`.

## Operation
- **Output stage states**
  - EMPTY: `o_l2_req_valid=0`.
  - HOLD: `o_l2_req_valid=1`.
- **Load condition:** the stage can load when it is EMPTY, or when it is in HOLD and `i_l2_req_ready=1` in the same cycle, giving pass-through at 1 request/cycle.
- **Eligibility:** `i_req_valid[i] && (!i_boot_mode || i==0)`.
- **Arbitration:** round-robin. Search starts at pointer `rr`, increments modulo `REQ_N`, and the first eligible requester wins. At most one `o_req_ready` bit is 1. Ready is 0 for all requesters when the stage cannot load.
- **On acceptance of requester g:**
  - Register `cmd`, `addr`, `data` and `byte_en`.
  - Register the tag as `{g[SRC_W-1:0], i_req_tag[g]}`.
  - Set `rr = (g+1) mod REQ_N`.
  - Next state is HOLD.
- **HOLD with `i_l2_req_ready=1` and no new grant:** next state is EMPTY.
- **HOLD with `i_l2_req_ready=0`:** all output fields are held stable and `rr` is unchanged.
- **Boot mode change:** a request already in HOLD completes regardless of `i_boot_mode` changes. Deasserting boot mode takes effect from the next arbitration cycle.
- **Response routing (registered):** on `i_l2_resp_valid`, `src = i_l2_resp_tag[TAG_W+:SRC_W]`.
  - If `src < REQ_N`: next cycle `o_resp_valid[src]=1`, `o_resp_tag=i_l2_resp_tag[TAG_W-1:0]`, `o_resp_data=i_l2_resp_data`.
  - Otherwise: the response is dropped and `o_route_err` is set until reset.
- `o_busy` equals the HOLD state.

## Timing
- **Reset values:**
  - `o_l2_req_valid=0`, `o_busy=0`, `o_resp_valid=0`, `o_route_err=0`, `rr=0`.
  - `o_l2_req_*` data fields and `o_resp_tag`/`o_resp_data` are 0.
  - `o_req_ready=0` while reset is asserted.
- **Request latency:** a request accepted in cycle N appears on `o_l2_req_*` in cycle N+1.
- **Throughput:** with `i_l2_req_ready` held at 1, one request per cycle.
- **Response latency:** 1 cycle. `o_resp_valid` is a single-cycle pulse per response.
- **Readiness:** `o_req_ready` is combinational from `i_req_valid`, `i_boot_mode`, the stage state and `i_l2_req_ready`. No requester's `o_req_ready` depends on its own ready.
- **Reset mid-operation:** a held request is discarded without handshake, and `rr` returns to 0.

## Test plan
- **Reset, single requester:** reset, `i_boot_mode=0`, requester 1 valid with addr `0x8000_0040` and tag 5, `i_l2_req_ready=1` → `o_req_ready[1]=1` in cycle 0. In cycle 1, `o_l2_req_valid=1`, addr `0x8000_0040`, `o_l2_req_tag={1,5}`.
- **Round-robin fairness:** all 3 requesters continuously valid, ready=1 → grant order 0,1,2,0,1,2, one per cycle, no gaps.
- **Backpressure:** ready=0 for 4 cycles while in HOLD → `o_l2_req_*` fields stable and all `o_req_ready=0`. Ready rises → accepted, and the next grant goes in the same cycle.
- **Boot mode:** `i_boot_mode=1` with requesters 0 and 2 valid → only requester 0 granted, for 10 consecutive cycles. Boot mode drops → requester 2 is granted within 2 cycles.
- **Response routing:** response with tag `{2,0x3}` and data `0xDEAD_BEEF` → next cycle `o_resp_valid=3'b100`, `o_resp_tag=3`. A response with `src=3` (`REQ_N=3`) → no `o_resp_valid` and `o_route_err=1` (sticky).
- **Reset mid-HOLD:** assert reset while `o_l2_req_valid=1` → `o_l2_req_valid=0` immediately (asynchronous), and the first grant after release goes to requester 0.
